// File: rtl/hamming_secded_engine.sv
// Extended-Hamming SECDED codec engine: bus master that streams NUM_MSG messages through byte-wide memory.
// Per message: 2*B_in reads + 1 calc + B_out writes + 1 step cycle; start is ignored while busy.
module hamming_secded_engine #(
   parameter int P        = 4,
   parameter int NUM_MSG  = 15,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 30,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        err_single_cnt,
   output logic [7:0]        err_double_cnt
);
   localparam int N     = 1 << P;
   localparam int K     = N - P - 1;
   localparam int B_RAW = (K + 7) / 8;
   localparam int B_CW  = N / 8;
   localparam int B_DEC = (K + 9) / 8;
   localparam int W_DEC = 8 * B_DEC;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_CAP, S_CALC, S_WRITE, S_NEXT, S_FIN
   } state_t;

   state_t            r_state, w_next;
   logic              r_mode, r_busy, r_done;
   logic [7:0]        r_msg;
   logic [2:0]        r_byte;
   logic [N-1:0]      r_inbuf, r_outbuf;
   logic [7:0]        r_single, r_double;

   logic [2:0]        w_b_in, w_b_out;
   logic              w_rd_last, w_wr_last;
   logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
   logic [P-1:0]      w_syn;
   logic              w_q;
   logic [1:0]        w_flags;
   logic [N-1:0]      w_corr, w_out;

   // Data bits occupy every non-power-of-two position in ascending order.
   function automatic logic [N-1:0] f_encode(input logic [K-1:0] d);
      logic [N-1:0] cw;
      logic         par;
      int           j;
      cw = '0;
      j  = 0;
      for (int pos = 1; pos < N; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos] = d[j];
            j++;
         end
      end
      for (int b = 0; b < P; b++) begin
         par = 1'b0;
         for (int pos = 1; pos < N; pos++)
            if (((pos >> b) & 1) != 0) par = par ^ cw[pos];
         cw[1 << b] = par;
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   function automatic logic [P-1:0] f_syndrome(input logic [N-1:0] cw);
      logic [P-1:0] s;
      s = '0;
      for (int b = 0; b < P; b++)
         for (int pos = 0; pos < N; pos++)
            if (((pos >> b) & 1) != 0) s[b] = s[b] ^ cw[pos];
      return s;
   endfunction

   function automatic logic [K-1:0] f_extract(input logic [N-1:0] cw);
      logic [K-1:0] d;
      int           j;
      d = '0;
      j = 0;
      for (int pos = 1; pos < N; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            d[j] = cw[pos];
            j++;
         end
      end
      return d;
   endfunction

   assign w_b_in    = r_mode ? 3'(B_CW)  : 3'(B_RAW);
   assign w_b_out   = r_mode ? 3'(B_DEC) : 3'(B_CW);
   assign w_rd_last = (r_byte == w_b_in - 3'd1);
   assign w_wr_last = (r_byte == w_b_out - 3'd1);
   assign w_rd_addr = ADDR_W'(SRC_BASE) + ADDR_W'(r_msg) * ADDR_W'(w_b_in) + ADDR_W'(r_byte);
   assign w_wr_addr = ADDR_W'(DST_BASE) + ADDR_W'(r_msg) * ADDR_W'(w_b_out) + ADDR_W'(r_byte);

   always_comb begin
      w_syn   = f_syndrome(r_inbuf);
      w_q     = ^r_inbuf;
      w_corr  = r_inbuf;
      w_flags = 2'b00;
      if (w_syn == '0) begin
         if (w_q) w_flags = 2'b01;
      end else if (w_q) begin
         w_corr[w_syn] = ~r_inbuf[w_syn];
         w_flags       = 2'b01;
      end else begin
         w_flags = 2'b10;
      end
      w_out = '0;
      if (r_mode) begin
         w_out[K-1:0]         = f_extract(w_corr);
         w_out[W_DEC-1 -: 2]  = w_flags;
      end else begin
         w_out = f_encode(r_inbuf[K-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      mem_wr_en = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         S_IDLE:    if (start) w_next = S_RD_ADDR;
         S_RD_ADDR: begin
            mem_addr = w_rd_addr;
            w_next   = S_RD_CAP;
         end
         S_RD_CAP:  w_next = w_rd_last ? S_CALC : S_RD_ADDR;
         S_CALC:    w_next = S_WRITE;
         S_WRITE: begin
            mem_wr_en = 1'b1;
            mem_addr  = w_wr_addr;
            mem_wdata = r_outbuf[8*r_byte +: 8];
            w_next    = w_wr_last ? S_NEXT : S_WRITE;
         end
         S_NEXT:    w_next = (r_msg == 8'(NUM_MSG - 1)) ? S_FIN : S_RD_ADDR;
         S_FIN:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mode   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_msg    <= '0;
         r_byte   <= '0;
         r_inbuf  <= '0;
         r_outbuf <= '0;
         r_single <= '0;
         r_double <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode   <= mode;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_msg    <= '0;
                  r_byte   <= '0;
                  r_single <= '0;
                  r_double <= '0;
               end
            end
            S_RD_CAP: begin
               r_inbuf[8*r_byte +: 8] <= mem_rdata;
               r_byte <= w_rd_last ? 3'd0 : r_byte + 3'd1;
            end
            S_CALC: begin
               r_outbuf <= w_out;
               if (r_mode) begin
                  if (w_flags == 2'b01 && r_single != 8'hFF) r_single <= r_single + 8'd1;
                  if (w_flags == 2'b10 && r_double != 8'hFF) r_double <= r_double + 8'd1;
               end
            end
            S_WRITE:   r_byte <= w_wr_last ? 3'd0 : r_byte + 3'd1;
            S_NEXT:    r_msg  <= r_msg + 8'd1;
            S_FIN: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign err_single_cnt = r_single;
   assign err_double_cnt = r_double;
endmodule

// File: tb/tb_hamming_secded_engine.sv
// Bench for hamming_secded_engine: three instances (P=4/3/5), each with its own byte memory.
module tb_hamming_secded_engine;
   logic            clk = 1'b0;
   logic            rst_n;
   logic [2:0]      start_v, mode_v, busy_v, done_v, we_v;
   logic [2:0][7:0] addr_v, wd_v, rd_v, sgl_v, dbl_v;
   logic [7:0]      src [3][256];
   logic [7:0]      dst [3][256];
   int              wr_cnt [3];
   logic            dst_clr;
   int              checks = 0;
   int              errors = 0;

   typedef struct {
      logic        m;
      logic [15:0] in_w;
      logic [15:0] exp_w;
      int          es;
      int          ed;
   } vec_t;

   always #5 clk = ~clk;

   hamming_secded_engine #(.P(4), .NUM_MSG(15), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8)) u_p4 (
      .clk(clk), .reset(rst_n), .start(start_v[0]), .mode(mode_v[0]), .busy(busy_v[0]),
      .done(done_v[0]), .mem_addr(addr_v[0]), .mem_wr_en(we_v[0]), .mem_wdata(wd_v[0]),
      .mem_rdata(rd_v[0]), .err_single_cnt(sgl_v[0]), .err_double_cnt(dbl_v[0]));

   hamming_secded_engine #(.P(3), .NUM_MSG(4), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8)) u_p3 (
      .clk(clk), .reset(rst_n), .start(start_v[1]), .mode(mode_v[1]), .busy(busy_v[1]),
      .done(done_v[1]), .mem_addr(addr_v[1]), .mem_wr_en(we_v[1]), .mem_wdata(wd_v[1]),
      .mem_rdata(rd_v[1]), .err_single_cnt(sgl_v[1]), .err_double_cnt(dbl_v[1]));

   hamming_secded_engine #(.P(5), .NUM_MSG(4), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8)) u_p5 (
      .clk(clk), .reset(rst_n), .start(start_v[2]), .mode(mode_v[2]), .busy(busy_v[2]),
      .done(done_v[2]), .mem_addr(addr_v[2]), .mem_wr_en(we_v[2]), .mem_wdata(wd_v[2]),
      .mem_rdata(rd_v[2]), .err_single_cnt(sgl_v[2]), .err_double_cnt(dbl_v[2]));

   // Source bytes belong to the bench, destination bytes to the DUTs.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         rd_v[i] <= src[i][addr_v[i]];
         if (dst_clr) begin
            wr_cnt[i] <= 0;
            for (int a = 0; a < 256; a++) dst[i][a] <= 8'h00;
         end else if (we_v[i]) begin
            dst[i][addr_v[i]] <= wd_v[i];
            wr_cnt[i]         <= wr_cnt[i] + 1;
         end
      end
   end

   function automatic int p_of(input int i);
      return (i == 0) ? 4 : (i == 1) ? 3 : 5;
   endfunction
   function automatic int nm_of(input int i);
      return (i == 0) ? 15 : 4;
   endfunction
   function automatic int bin_of(input int i, input logic m);
      int n, k;
      n = 1 << p_of(i);
      k = n - p_of(i) - 1;
      return m ? n / 8 : (k + 7) / 8;
   endfunction
   function automatic int bout_of(input int i, input logic m);
      int n, k;
      n = 1 << p_of(i);
      k = n - p_of(i) - 1;
      return m ? (k + 9) / 8 : n / 8;
   endfunction
   function automatic int expcyc(input int i, input logic m);
      return 2 + nm_of(i) * (2 * bin_of(i, m) + 2 + bout_of(i, m));
   endfunction

   // Reference: parity bits are chosen so the XOR of all set positions is zero.
   function automatic logic [31:0] m_encode(input int p, input logic [31:0] d);
      int n, j, s;
      logic [31:0] cw;
      n = 1 << p; j = 0; s = 0; cw = '0;
      for (int pos = 1; pos < n; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos] = d[j];
            if (d[j]) s = s ^ pos;
            j++;
         end
      end
      for (int b = 0; b < p; b++)
         if (((s >> b) & 1) != 0) cw[1 << b] = 1'b1;
      cw[0] = ^cw;
      return cw;
   endfunction

   function automatic logic [31:0] m_decode(input int p, input logic [31:0] cw, output logic [1:0] fl);
      int n, k, bdec, s, j;
      logic q;
      logic [31:0] c, d;
      n = 1 << p; k = n - p - 1; bdec = (k + 9) / 8; s = 0;
      for (int pos = 0; pos < n; pos++)
         if (cw[pos]) s = s ^ pos;
      q = ^cw;
      c = cw;
      if (s == 0) fl = q ? 2'b01 : 2'b00;
      else if (q) begin
         fl   = 2'b01;
         c[s] = ~c[s];
      end else fl = 2'b10;
      d = '0; j = 0;
      for (int pos = 1; pos < n; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            d[j] = c[pos];
            j++;
         end
      end
      return d | (32'(fl) << (8 * bdec - 2));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp_v);
      end
   endtask

   task automatic prepare(input int i, input logic m, input bit inj);
      int p, n, bin, nf, b1, b2;
      logic [31:0] w;
      p = p_of(i); n = 1 << p; bin = bin_of(i, m);
      @(negedge clk) dst_clr = 1'b1;
      @(negedge clk) dst_clr = 1'b0;
      for (int msg = 0; msg < nm_of(i); msg++) begin
         w = $urandom;
         if (m) begin
            w = m_encode(p, w);
            if (inj) begin
               nf = $urandom_range(0, 2);
               b1 = $urandom_range(0, n - 1);
               b2 = (b1 + $urandom_range(1, n - 1)) % n;
               if (nf >= 1) w[b1] = ~w[b1];
               if (nf == 2) w[b2] = ~w[b2];
            end
         end
         for (int b = 0; b < bin; b++) src[i][msg*bin + b] = w[8*b +: 8];
      end
   endtask

   task automatic do_run(input int i, input logic m, input bit poke, output int ncyc);
      bit busy_ok;
      busy_ok = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b1;
      mode_v[i]  = m;
      @(negedge clk);
      start_v[i] = 1'b0;
      mode_v[i]  = ~m;
      ncyc = 1;
      chk("done_drop", done_v[i], 0);
      while (!done_v[i] && ncyc < 2000) begin
         if (!busy_v[i]) busy_ok = 1'b0;
         if (poke && ncyc == 40) start_v[i] = 1'b1;
         if (poke && ncyc == 41) start_v[i] = 1'b0;
         @(negedge clk);
         ncyc++;
      end
      start_v[i] = 1'b0;
      chk("busy_during_run", busy_ok, 1);
      chk("done_seen", done_v[i], 1);
      chk("busy_at_done", busy_v[i], 0);
   endtask

   task automatic check_run(input int i, input logic m);
      int p, bin, bout, ms, md;
      logic [31:0] w, exp_w, act_w;
      logic [1:0] fl;
      p = p_of(i); bin = bin_of(i, m); bout = bout_of(i, m); ms = 0; md = 0;
      for (int msg = 0; msg < nm_of(i); msg++) begin
         w = '0;
         for (int b = 0; b < bin; b++) w[8*b +: 8] = src[i][msg*bin + b];
         if (m) begin
            exp_w = m_decode(p, w, fl);
            if (fl == 2'b01) ms++;
            if (fl == 2'b10) md++;
         end else exp_w = m_encode(p, w);
         act_w = '0;
         for (int b = 0; b < bout; b++) act_w[8*b +: 8] = dst[i][30 + msg*bout + b];
         chk($sformatf("p%0d_mode%0d_msg%0d", p, m, msg), act_w, exp_w);
      end
      chk($sformatf("p%0d_single_cnt", p), sgl_v[i], ms);
      chk($sformatf("p%0d_double_cnt", p), dbl_v[i], md);
      chk($sformatf("p%0d_write_count", p), wr_cnt[i], nm_of(i) * bout);
   endtask

   initial begin
      int          nc;
      logic [15:0] act;
      vec_t        tbl [10];

      rst_n = 1'b0; dst_clr = 1'b0; start_v = '0; mode_v = '0;
      for (int i = 0; i < 3; i++)
         for (int a = 0; a < 256; a++) src[i][a] = 8'h00;

      // P=4 vectors; message 0 of a 15-message run, remaining messages clean filler.
      tbl[0] = '{1'b0, 16'h05A3, 16'hB42D, 0, 0};
      tbl[1] = '{1'b1, 16'hB42D, 16'h05A3, 0, 0};
      tbl[2] = '{1'b1, 16'hB46D, 16'h45A3, 1, 0};
      tbl[3] = '{1'b1, 16'hB42C, 16'h45A3, 1, 0};
      tbl[4] = '{1'b1, 16'hB66D, 16'h85B7, 0, 1};
      tbl[5] = '{1'b0, 16'h0000, 16'h0000, 0, 0};
      tbl[6] = '{1'b0, 16'h07FF, 16'hFFFF, 0, 0};
      tbl[7] = '{1'b0, 16'hFDA3, 16'hB42D, 0, 0};
      tbl[8] = '{1'b1, 16'hFFFF, 16'h07FF, 0, 0};
      tbl[9] = '{1'b1, 16'h342D, 16'h45A3, 1, 0};

      repeat (3) @(negedge clk);
      chk("rst_busy", busy_v[0], 0);
      chk("rst_done", done_v[0], 0);
      chk("rst_wr_en", we_v[0], 0);
      chk("rst_addr", addr_v[0], 0);
      chk("rst_wdata", wd_v[0], 0);
      chk("rst_single", sgl_v[0], 0);
      chk("rst_double", dbl_v[0], 0);
      rst_n = 1'b1;

      for (int r = 0; r < 10; r++) begin
         prepare(0, tbl[r].m, 1'b0);
         src[0][0] = tbl[r].in_w[7:0];
         src[0][1] = tbl[r].in_w[15:8];
         do_run(0, tbl[r].m, 1'b0, nc);
         act = {dst[0][31], dst[0][30]};
         chk($sformatf("vec%0d_word", r), act, tbl[r].exp_w);
         chk($sformatf("vec%0d_single", r), sgl_v[0], tbl[r].es);
         chk($sformatf("vec%0d_double", r), dbl_v[0], tbl[r].ed);
         chk($sformatf("vec%0d_cycles", r), nc, 122);
         check_run(0, tbl[r].m);
      end

      // Random encode run with an ignored start at cycle 40.
      prepare(0, 1'b0, 1'b0);
      do_run(0, 1'b0, 1'b1, nc);
      chk("enc_run_cycles", nc, 122);
      check_run(0, 1'b0);

      // Random decode with 0/1/2 flipped bits, then encode must clear counters.
      for (int t = 0; t < 3; t++) begin
         prepare(0, 1'b1, 1'b1);
         do_run(0, 1'b1, 1'b0, nc);
         chk("dec_run_cycles", nc, 122);
         check_run(0, 1'b1);
      end
      prepare(0, 1'b0, 1'b0);
      do_run(0, 1'b0, 1'b0, nc);
      check_run(0, 1'b0);

      // Reset asserted at cycle 20 of a run aborts it.
      prepare(0, 1'b0, 1'b0);
      @(negedge clk);
      start_v[0] = 1'b1;
      mode_v[0]  = 1'b0;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy_v[0], 0);
      chk("midrst_done", done_v[0], 0);
      chk("midrst_wr_en", we_v[0], 0);
      rst_n = 1'b1;
      prepare(0, 1'b0, 1'b0);
      do_run(0, 1'b0, 1'b0, nc);
      chk("post_rst_cycles", nc, 122);
      check_run(0, 1'b0);

      // Narrow (P=3) and wide (P=5) geometries.
      for (int i = 1; i < 3; i++) begin
         for (int m = 0; m < 2; m++) begin
            prepare(i, m[0], m[0]);
            do_run(i, m[0], 1'b0, nc);
            chk($sformatf("p%0d_mode%0d_cycles", p_of(i), m), nc, expcyc(i, m[0]));
            check_run(i, m[0]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
